// File: rtl/adder_seq_n.sv
// Sequential add/subtract unit: one N-bit slice adder reused over K cycles.
// Operands are captured on accept; the result is held until the consumer takes it.
module adder_seq_n #(
    parameter int N = 4,
    parameter int K = 2,
    parameter int W = N * K
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    input  logic         SUB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] SUM,
    output logic         Cout,
    output logic         OVF
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          ovf_q;

    logic [N-1:0]  a_s;
    logic [N-1:0]  b_s;
    logic [N-1:0]  s_s;
    logic          c_s;
    logic          msb_cin;
    logic          last;

    // Slice datapath; msb_cin is the carry into the top bit of the current slice.
    always_comb begin
        a_s = op_a[int'(idx) * N +: N];
        b_s = op_b[int'(idx) * N +: N];
        {c_s, s_s} = {1'b0, a_s} + {1'b0, b_s} + {{N{1'b0}}, carry};
        msb_cin = a_s[N-1] ^ b_s[N-1] ^ s_s[N-1];
        last = (idx == IW'(K - 1));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= A;
                        op_b  <= SUB ? ~B : B;
                        carry <= SUB ? ~Cin : Cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[int'(idx) * N +: N] <= s_s;
                    carry <= c_s;
                    if (last) begin
                        cout_q <= c_s;
                        ovf_q  <= msb_cin ^ c_s;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign SUM       = sum_q;
    assign Cout      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: doc/adder_seq_n.md
Name: adder_seq_n

Overview:
- Multi-cycle, parametrised add/subtract unit for W = N*K bit operands.
- Reuses one N-bit slice adder over K cycles, holding the inter-slice carry in a register.
- Successor to the combinational two-stage cascaded N-bit adder. Adds operand capture, subtract/borrow mode, signed overflow, and valid/ready handshakes on both sides.
- Sits between a register-file/operand source and a result consumer in the datapath exercises.

Parameters:
- N, 4, slice width in bits (N >= 1).
- K, 2, number of slices processed sequentially (K >= 1).
- W, N*K, operand/result width (derived; must not be overridden).

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands.
- A  in  W  operand A, unsigned or two's complement.
- B  in  W  operand B.
- Cin  in  1  carry-in (ADD) or borrow-in (SUB).
- SUB  in  1  0 = A+B+Cin, 1 = A-B-Cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- SUM  out  W  result.
- Cout  out  1  raw carry out of the MSB (in SUB mode 1 = no borrow).
- OVF  out  1  signed overflow.

Behaviour:
- Reset (n_reset low, asynchronous):
  - state = IDLE; SUM = 0, Cout = 0, OVF = 0, out_valid = 0; slice index = 0; carry register = 0.
  - in_ready = 1, since it is decoded from IDLE.
- States: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE), registered.
- IDLE:
  - On a rising edge with in_valid & in_ready, capture opA = A and opB = SUB ? ~B : B.
  - Set carry = SUB ? ~Cin : Cin, index = 0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN (one slice per cycle), at slice i = index:
  - {c, s} = opA[i] + opB[i] + carry.
  - SUM[i*N +: N] <= s; carry <= c; index <= index + 1.
  - On the last slice (index == K-1):
    - Cout <= c.
    - OVF <= carry into the MSB XOR carry out of the MSB, computed inside the top slice.
    - Go to DONE.
- DONE:
  - SUM, Cout and OVF are held stable.
  - If out_ready is high at the edge, go to IDLE.
  - No new operand is accepted in the same cycle as result release; the next accept is earliest one cycle later.
- Latency:
  - Operands are accepted at edge t0.
  - out_valid rises after edge t0+K.
  - Minimum initiation interval is K+2 cycles.
  - K=1 gives exactly one RUN cycle.
- Operand stability: A, B, Cin and SUB may change freely after acceptance without affecting the result.
- in_valid while busy: ignored while in RUN or DONE. Nothing is queued or dropped silently into state; the producer must hold until in_ready.
- SUM during RUN: lower slices update progressively. SUM is only valid when out_valid = 1.
- Cout and OVF: hold their previous values until the last RUN slice.
- Reset mid-operation: aborts immediately to the reset state. No partial result is presented.
- Width rules:
  - All arithmetic is modulo 2^W.
  - {Cout, SUM} equals the exact (W+1)-bit value A + B + Cin in ADD mode, and A + ~B + ~Cin in SUB mode.

Test Plan (N=4, K=2 unless stated):
1. ADD 0x5A+0x33, Cin=0 -> out_valid 2 cycles after accept; SUM=0x8D, Cout=0, OVF=1.
2. ADD 0xFF+0x01, Cin=0 -> SUM=0x00, Cout=1, OVF=0. ADD 0x00+0x00, Cin=1 -> SUM=0x01, Cout=0.
3. SUB 0x10-0x01, Cin=0 -> SUM=0x0F, Cout=1, OVF=0. SUB 0x80-0x01 -> SUM=0x7F, Cout=1, OVF=1. SUB 0x00-0x01 -> SUM=0xFF, Cout=0, OVF=0.
4. Backpressure: hold out_ready=0 for 5 cycles while pulsing in_valid with new operands.
   -> SUM, Cout and OVF are unchanged and in_ready=0 throughout.
   -> After out_ready=1, the block returns to IDLE and the next operands are accepted one cycle later.
5. Reset: drive n_reset low one cycle into RUN.
   -> SUM=0, Cout=0, OVF=0, out_valid=0 immediately, with no clock edge needed.
   -> After release, a fresh 0x01+0x01 gives SUM=0x02.
6. Exhaustive: all A, B in 0..255, both SUB values, both Cin values, each checked against an integer model ({Cout,SUM} and OVF).
   -> Repeat with N=3, K=3 (W=9) and N=8, K=1 (single RUN cycle, latency 1).
